// File: rtl/rf_multi.sv
// Parametrised 2-read/1-write register file with registered, bypassed reads,
// per-entry valid bits and a sweep-clear sequencer. Define RF_ZERO_REG_EN to hardwire entry 0.
module rf_multi #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rea,
  input  logic [AW-1:0]    raa,
  input  logic             reb,
  input  logic [AW-1:0]    rab,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] douta,
  output logic [WIDTH-1:0] doutb,
  output logic             dva,
  output logic             dvb,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q;
  logic [AW-1:0]    ptr_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [WIDTH-1:0] douta_d, douta_q, doutb_d, doutb_q;
  logic             dva_d, dva_q, dvb_d, dvb_q;
  logic             wr_ok;
  logic             wr_en;

  // wr_ok: the write itself is legal (bypass source); wr_en: it also lands in the array.
  always_comb begin
`ifdef RF_ZERO_REG_EN
    wr_ok = we && (wa != '0);
`else
    wr_ok = we;
`endif
    wr_en = wr_ok && (state_q == StIdle) && !clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (state_q == StClear) begin
      mem_q[ptr_q]   <= '0;
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_en) begin
      mem_q[wa]   <= din;
      valid_q[wa] <= 1'b1;
    end
  end

  always_comb begin
    douta_d = '0;
    dva_d   = 1'b0;
    if (!busy_q && rea) begin
      if (wr_ok && (wa == raa)) begin
        douta_d = din;
        dva_d   = 1'b1;
      end else begin
        douta_d = mem_q[raa];
        dva_d   = valid_q[raa];
      end
`ifdef RF_ZERO_REG_EN
      if (raa == '0) begin
        douta_d = '0;
        dva_d   = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    doutb_d = '0;
    dvb_d   = 1'b0;
    if (!busy_q && reb) begin
      if (wr_ok && (wa == rab)) begin
        doutb_d = din;
        dvb_d   = 1'b1;
      end else begin
        doutb_d = mem_q[rab];
        dvb_d   = valid_q[rab];
      end
`ifdef RF_ZERO_REG_EN
      if (rab == '0) begin
        doutb_d = '0;
        dvb_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
      dva_q   <= 1'b0;
      dvb_q   <= 1'b0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
      dva_q   <= dva_d;
      dvb_q   <= dvb_d;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;
  assign dva   = dva_q;
  assign dvb   = dvb_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rf_multi.sv
// Scoreboard bench for rf_multi: stimulus pushes expected post-edge outputs, a monitor
// pops and compares one entry after every rising edge.
module tb_rf_multi;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             rea = 1'b0, reb = 1'b0, we = 1'b0, clr = 1'b0;
  logic [AW-1:0]    raa = '0, rab = '0, wa = '0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] douta, doutb;
  logic             dva, dvb, busy;

  always #5 clk = ~clk;

  rf_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rea   (rea),
    .raa   (raa),
    .reb   (reb),
    .rab   (rab),
    .we    (we),
    .wa    (wa),
    .din   (din),
    .clr   (clr),
    .douta (douta),
    .doutb (doutb),
    .dva   (dva),
    .dvb   (dvb),
    .busy  (busy)
  );

  typedef struct {
    string      name;
    logic       ca;
    logic [3:0] ea;
    logic       cb;
    logic [3:0] eb;
    logic       cbz;
    logic       bz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef RF_ZERO_REG_EN
  localparam logic [3:0] Zero3  = {3'd0, 1'b1};  // entry 0 after writing 3
  localparam logic [3:0] ZeroCl = {3'd0, 1'b1};  // entry 0 after a sweep
`else
  localparam logic [3:0] Zero3  = {3'd3, 1'b1};
  localparam logic [3:0] ZeroCl = {3'd0, 1'b0};
`endif

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.ca)  check({mon_e.name, "/A"}, {douta, dva}, mon_e.ea);
        if (mon_e.cb)  check({mon_e.name, "/B"}, {doutb, dvb}, mon_e.eb);
        if (mon_e.cbz) check({mon_e.name, "/busy"}, {3'b000, busy}, {3'b000, mon_e.bz});
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue what must appear after the next rise.
  task automatic step(input string name,
                      input logic i_rea, input logic [1:0] i_raa,
                      input logic i_reb, input logic [1:0] i_rab,
                      input logic i_we, input logic [1:0] i_wa, input logic [2:0] i_din,
                      input logic i_clr,
                      input logic ca, input logic [3:0] ea,
                      input logic cb, input logic [3:0] eb,
                      input logic cbz, input logic bz);
    exp_t e;
    @(negedge clk);
    rea = i_rea; raa = i_raa; reb = i_reb; rab = i_rab;
    we = i_we; wa = i_wa; din = i_din; clr = i_clr;
    e.name = name; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb; e.cbz = cbz; e.bz = bz;
    exp_q.push_back(e);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_a", {douta, dva}, 4'b0000);
    check("reset_b", {doutb, dvb}, 4'b0000);
    check("reset_busy", {3'b000, busy}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   name         rea raa  reb rab  we  wa  din   clr   A check         B check        busy
    step("rd_empty",  1, 2'd2, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      0, 4'b0000,     1, 0);
    step("wr1",       0, 2'd1, 0, 2'd0, 1, 2'd1, 3'd5, 0,  1, 4'b0000,      0, 4'b0000,     1, 0);
    step("rd1",       1, 2'd1, 1, 2'd1, 0, 2'd0, 3'd0, 0,  1, {3'd5, 1'b1}, 1, {3'd5, 1'b1}, 0, 0);
    step("rd1_off",   0, 2'd1, 0, 2'd1, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      1, 4'b0000,     0, 0);
    step("bypass3",   1, 2'd3, 1, 2'd3, 1, 2'd3, 3'd6, 0,  1, {3'd6, 1'b1}, 1, {3'd6, 1'b1}, 0, 0);
    step("wr0_byp",   1, 2'd0, 0, 2'd0, 1, 2'd0, 3'd3, 0,  1, Zero3,        0, 4'b0000,     0, 0);
    step("rd0",       1, 2'd0, 1, 2'd3, 0, 2'd0, 3'd0, 0,  1, Zero3,        1, {3'd6, 1'b1}, 0, 0);
    step("bypass2b",  0, 2'd0, 1, 2'd2, 1, 2'd2, 3'd7, 0,  1, 4'b0000,      1, {3'd7, 1'b1}, 0, 0);
    // Sweep: edge sampling clr still reads normally, then busy for exactly DEPTH edges.
    step("clr_e0",    1, 2'd2, 1, 2'd1, 0, 2'd0, 3'd0, 1,  1, {3'd7, 1'b1}, 1, {3'd5, 1'b1}, 1, 1);
    step("clr_e1_wr", 1, 2'd1, 1, 2'd1, 1, 2'd1, 3'd2, 0,  1, 4'b0000,      1, 4'b0000,     1, 1);
    step("clr_e2",    1, 2'd3, 0, 2'd0, 0, 2'd0, 3'd0, 1,  1, 4'b0000,      0, 4'b0000,     1, 1);
    step("clr_e3",    1, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      0, 4'b0000,     1, 1);
    step("clr_e4",    1, 2'd2, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      0, 4'b0000,     1, 0);
    step("post_wr",   1, 2'd1, 1, 2'd3, 1, 2'd2, 3'd4, 0,  1, 4'b0000,      1, 4'b0000,     1, 0);
    step("post_rd",   1, 2'd2, 1, 2'd0, 0, 2'd0, 3'd0, 0,  1, {3'd4, 1'b1}, 1, ZeroCl,      1, 0);
    // clr and we together: clear wins, write to entry 2 is dropped.
    step("clrwe_e0",  0, 2'd0, 0, 2'd0, 1, 2'd2, 3'd7, 1,  1, 4'b0000,      0, 4'b0000,     1, 1);
    step("clrwe_e1",  0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  0, 4'b0000,      0, 4'b0000,     1, 1);
    step("clrwe_e2",  0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  0, 4'b0000,      0, 4'b0000,     1, 1);
    step("clrwe_e3",  0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  0, 4'b0000,      0, 4'b0000,     1, 1);
    step("clrwe_e4",  0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  0, 4'b0000,      0, 4'b0000,     1, 0);
    step("clrwe_rd",  1, 2'd2, 1, 2'd3, 1, 2'd1, 3'd1, 0,  1, 4'b0000,      1, 4'b0000,     1, 0);
    // Start another sweep and abort it with reset during its second cycle.
    step("abort_e0",  1, 2'd1, 0, 2'd0, 0, 2'd0, 3'd0, 1,  1, {3'd1, 1'b1}, 0, 4'b0000,     1, 1);
    step("abort_e1",  0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      0, 4'b0000,     1, 1);
    @(negedge clk);
    clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {3'b000, busy}, 4'b0000);
    check("abort_a", {douta, dva}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_wr",    1, 2'd1, 0, 2'd0, 1, 2'd3, 3'd1, 0,  1, 4'b0000,      0, 4'b0000,     1, 0);
    step("rst_rd",    1, 2'd3, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, {3'd1, 1'b1}, 0, 4'b0000,     1, 0);
    step("idle",      0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0,  1, 4'b0000,      0, 4'b0000,     1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
